// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings and request decode helpers.
// Used by the responder and reusable by the CPU-side stall logic.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam int WAIT_CYCLES_DEF = 2;
   localparam int CNT_W           = 4;

   function automatic logic misaligned(input logic [1:0] byte_off);
      return byte_off != 2'b00;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM, read-before-write.
// Latency: rdata valid one cycle after idx is presented; no backpressure.
// Backpressure: none, accepts a write on any cycle we is high.
module dmem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a MemRead/MemWrite request and completes it after wait states.
// Latency: stall high WAIT_CYCLES+2 cycles per request, ack pulses the cycle after.
// Backpressure: stall holds the pipeline; inputs are ignored in DONE and while busy.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd,
   output logic              stall,
   output logic              ack,
   output logic              err
);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                op_rd;
   logic                op_wr;
   logic                lat_mis;
   logic [ADDR_W-1:0]   lat_idx;
   logic [DATA_W-1:0]   lat_wd;

   logic                req;
   logic                finish;
   logic                conflict;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_idx;
   logic [DATA_W-1:0]   ram_rdata;
   logic                unused_addr_bits;

   assign req      = MemRead | MemWrite;
   assign finish   = (state == S_ACCESS) && (cnt == '0);
   assign conflict = op_rd & op_wr;

   // The RAM sees the live index in IDLE so its read data is ready from the first ACCESS cycle on,
   // which keeps WAIT_CYCLES=0 working with a registered RAM.
   assign ram_idx = (state == S_IDLE) ? addr[ADDR_W+1:2] : lat_idx;
   assign ram_we  = finish && op_wr && !op_rd && !lat_mis && !rst;

   assign stall = !rst && (((state == S_IDLE) && req) || (state == S_ACCESS));

   assign unused_addr_bits = ^addr[31:ADDR_W+2];

   dmem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .idx   (ram_idx),
      .wdata (lat_wd),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         rd      <= '0;
         ack     <= 1'b0;
         err     <= 1'b0;
         op_rd   <= 1'b0;
         op_wr   <= 1'b0;
         lat_mis <= 1'b0;
         lat_idx <= '0;
         lat_wd  <= '0;
      end else begin
         ack <= finish;
         case (state)
            S_IDLE: begin
               if (req) begin
                  op_rd   <= MemRead;
                  op_wr   <= MemWrite;
                  lat_mis <= misaligned(addr[1:0]);
                  lat_idx <= addr[ADDR_W+1:2];
                  lat_wd  <= wd;
                  cnt     <= CNT_W'(WAIT_CYCLES);
                  state   <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  if (conflict || lat_mis) begin
                     err <= 1'b1;
                  end
                  // A conflicting request leaves rd untouched; a misaligned read returns zero.
                  if (op_rd && !op_wr) begin
                     rd <= lat_mis ? '0 : ram_rdata;
                  end
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed requests against a transaction-level memory model,
// with every cycle's stall/ack/rd/err compared to the model's expectation.
module tb_dmem_responder;

   localparam int W  = 2;
   localparam int AW = 8;

   logic        clk;
   logic        rst;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        stall;
   logic        ack;
   logic        err;

   logic        chk_en;
   logic        exp_stall;
   logic        exp_ack;
   logic        exp_err;
   logic [31:0] exp_rd;
   logic [31:0] mem_m [int];

   int total;
   int bad;

   dmem_responder #(
      .ADDR_W      (AW),
      .WAIT_CYCLES (W),
      .DATA_W      (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .addr     (addr),
      .wd       (wd),
      .rd       (rd),
      .stall    (stall),
      .ack      (ack),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h at t=%0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", {31'b0, stall}, {31'b0, exp_stall});
         check("ack",   {31'b0, ack},   {31'b0, exp_ack});
         check("err",   {31'b0, err},   {31'b0, exp_err});
         check("rd",    rd,             exp_rd);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request held until completion: stall for W+2 cycles, then a single ack cycle.
   task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit wiggle);
      int idx;
      bit mis;
      idx = int'((a >> 2) % (32'd1 << AW));
      mis = (a % 4) != 0;
      MemRead   = r;
      MemWrite  = w;
      addr      = a;
      wd        = d;
      exp_stall = 1'b1;
      exp_ack   = 1'b0;
      for (int k = 0; k < W + 2; k++) begin
         if (wiggle && k > 0) begin
            addr = a ^ 32'h44;
            wd   = ~d;
         end
         step();
      end
      exp_stall = 1'b0;
      exp_ack   = 1'b1;
      if (r && w) begin
         exp_err = 1'b1;
      end else begin
         if (mis) exp_err = 1'b1;
         if (r) exp_rd = mis ? 32'h0 : mem_m[idx];
         else if (!mis) mem_m[idx] = d;
      end
      step();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      exp_ack  = 1'b0;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      chk_en    = 1'b0;
      rst       = 1'b1;
      MemRead   = 1'b1;
      MemWrite  = 1'b0;
      addr      = 32'h0;
      wd        = 32'h0;
      exp_stall = 1'b0;
      exp_ack   = 1'b0;
      exp_err   = 1'b0;
      exp_rd    = 32'h0;

      // Reset held two cycles with a read request present.
      step();
      chk_en = 1'b1;
      step();
      rst     = 1'b0;
      MemRead = 1'b0;
      step();
      check("rst_rd_lit", rd, 32'h0);
      check("rst_err_lit", {31'b0, err}, 32'h0);

      do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      step();
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      check("wr_rd_lit", rd, 32'hDEADBEEF);

      // Back-to-back writes with no idle cycle between.
      do_req(1'b0, 1'b1, 32'h8, 32'h11, 1'b0);
      do_req(1'b0, 1'b1, 32'h20, 32'h2020, 1'b0);
      step();

      do_req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
      check("mis_rd_lit", rd, 32'h0);
      check("mis_err_lit", {31'b0, err}, 32'h1);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      check("mis_reread_lit", rd, 32'hDEADBEEF);

      do_req(1'b1, 1'b1, 32'h20, 32'h1, 1'b0);
      do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      check("conflict_old_lit", rd, 32'h2020);

      do_req(1'b0, 1'b1, 32'h400, 32'h55, 1'b0);
      do_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("wrap_lit", rd, 32'h55);

      do_req(1'b0, 1'b1, 32'h11, 32'h999, 1'b0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

      // Inputs change while stalled; the latched request must win.
      do_req(1'b0, 1'b1, 32'h30, 32'h1234, 1'b1);
      do_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
      check("latched_lit", rd, 32'h1234);
      step();

      // Reset in the second ACCESS cycle of a write aborts it.
      MemWrite  = 1'b1;
      addr      = 32'h8;
      wd        = 32'hAA;
      exp_stall = 1'b1;
      step();
      step();
      rst       = 1'b1;
      exp_stall = 1'b0;
      step();
      rst      = 1'b0;
      MemWrite = 1'b0;
      exp_rd   = 32'h0;
      exp_err  = 1'b0;
      step();
      check("abort_err_lit", {31'b0, err}, 32'h0);
      do_req(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
      check("abort_rd_lit", rd, 32'h11);
      step();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
